messbauer_sequencer: RTL and testbench

- Runtime-configurable successor to the fixed-parameter Mossbauer start/channel generator on the AX309 test environment.
- Produces one start frame followed by 2^k channel periods, each ending with a channel strobe.
- Channel count, channel period, strobe width, mode and frame count are programmable per frame; all are latched at frame start.
- Adds enable/abort control, frame counting, busy/index status and a frame_done pulse for the stimulus controller.

---
 rtl/messbauer_pkg.sv | 25 ++
 rtl/messbauer_cfg_latch.sv | 60 ++++++
 rtl/messbauer_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_messbauer_sequencer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/messbauer_pkg.sv
// Shared definitions for the Mossbauer start/channel sequencer: state encoding,
// mode constants, default timing values and a saturating counter helper.
package messbauer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_START_LOW  = 2'd1,
        ST_CHANNEL    = 2'd2,
        ST_START_HIGH = 2'd3
    } state_t;

    localparam logic CHANNEL_AFTER_MEASURE  = 1'b0;
    localparam logic START_AND_CHANNEL_SYNC = 1'b1;

    localparam int DEFAULT_GCLK_PERIOD         = 20;
    localparam int DEFAULT_START_DURATION      = 50;
    localparam int DEFAULT_START_HIGH_DURATION = 773200;
    localparam int DEFAULT_MAX_CHANNEL_NUMBER  = 4096;
    localparam int DEFAULT_DUR_W               = 24;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/messbauer_cfg_latch.sv
// Captures the per-frame configuration on a load strobe and normalises it:
// k clamped to [1, log2(MAX_CHANNEL_NUMBER)], D=0 promoted to 1, strobe only when 0<G<D.
module messbauer_cfg_latch
    import messbauer_pkg::*;
#(
    parameter int MAX_CHANNEL_NUMBER = DEFAULT_MAX_CHANNEL_NUMBER,
    parameter int DUR_W              = DEFAULT_DUR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [3:0]       cfg_channel_log2,
    input  logic [DUR_W-1:0] cfg_channel_duration,
    input  logic [DUR_W-1:0] cfg_guard,
    input  logic             cfg_mode,
    input  logic [15:0]      cfg_frames,
    output logic [3:0]       k,
    output logic [DUR_W-1:0] dur,
    output logic [DUR_W-1:0] guard,
    output logic             strobe_en,
    output logic             mode,
    output logic [15:0]      frames
);

    localparam int K_MAX = $clog2(MAX_CHANNEL_NUMBER);

    logic [3:0]       k_clamped;
    logic [DUR_W-1:0] dur_clamped;
    logic             strobe_ok;

    always_comb begin
        k_clamped = cfg_channel_log2;
        if (cfg_channel_log2 == 4'd0) begin
            k_clamped = 4'd1;
        end else if (cfg_channel_log2 > 4'(K_MAX)) begin
            k_clamped = 4'(K_MAX);
        end
        dur_clamped = (cfg_channel_duration == '0) ? DUR_W'(1) : cfg_channel_duration;
        strobe_ok   = (cfg_guard != '0) && (cfg_guard < dur_clamped);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= 4'd1;
            dur       <= DUR_W'(1);
            guard     <= '0;
            strobe_en <= 1'b0;
            mode      <= CHANNEL_AFTER_MEASURE;
            frames    <= 16'd0;
        end else if (load) begin
            k         <= k_clamped;
            dur       <= dur_clamped;
            guard     <= cfg_guard;
            strobe_en <= strobe_ok;
            mode      <= cfg_mode;
            frames    <= cfg_frames;
        end
    end

endmodule

// File: rtl/messbauer_sequencer.sv
// Runtime-configurable Mossbauer start/channel generator: one start frame followed
// by 2^k channel periods, with frame counting, abort and per-frame config latching.
module messbauer_sequencer
    import messbauer_pkg::*;
#(
    parameter int GCLK_PERIOD         = DEFAULT_GCLK_PERIOD,
    parameter int START_DURATION      = DEFAULT_START_DURATION,
    parameter int START_HIGH_DURATION = DEFAULT_START_HIGH_DURATION,
    parameter int MAX_CHANNEL_NUMBER  = DEFAULT_MAX_CHANNEL_NUMBER,
    parameter int DUR_W               = DEFAULT_DUR_W,
    parameter int IDX_W               = $clog2(MAX_CHANNEL_NUMBER)
) (
    input  logic             aclk,
    input  logic             areset_n,
    input  logic             enable,
    input  logic             abort,
    input  logic [3:0]       cfg_channel_log2,
    input  logic [DUR_W-1:0] cfg_channel_duration,
    input  logic [DUR_W-1:0] cfg_guard,
    input  logic             cfg_mode,
    input  logic [15:0]      cfg_frames,
    output logic             start,
    output logic             channel,
    output logic             busy,
    output logic [IDX_W-1:0] channel_index,
    output logic [15:0]      frame_count,
    output logic             frame_done
);

    if (GCLK_PERIOD < 1 || START_DURATION < 1 || START_HIGH_DURATION < 1 ||
        MAX_CHANNEL_NUMBER < 2 ||
        (MAX_CHANNEL_NUMBER & (MAX_CHANNEL_NUMBER - 1)) != 0) begin : g_param_check
        $error("messbauer_sequencer: invalid timing or channel-count parameters");
    end

    localparam logic [DUR_W-1:0] SL_LAST = DUR_W'(START_DURATION - 1);
    localparam logic [DUR_W-1:0] SH_LAST = DUR_W'(START_HIGH_DURATION - 1);

    state_t           state;
    logic [DUR_W-1:0] cnt;
    logic [DUR_W-1:0] cnt_inc;
    logic [DUR_W-1:0] threshold;
    logic [IDX_W:0]   chan_span;
    logic [IDX_W-1:0] last_index;
    logic             limit_hit;
    logic             load;

    logic [3:0]       k_eff;
    logic [DUR_W-1:0] dur_eff;
    logic [DUR_W-1:0] guard_eff;
    logic             strobe_en;
    logic             mode_eff;
    logic [15:0]      frames_eff;

    messbauer_cfg_latch #(
        .MAX_CHANNEL_NUMBER (MAX_CHANNEL_NUMBER),
        .DUR_W              (DUR_W)
    ) u_cfg_latch (
        .clk                  (aclk),
        .rst_n                (areset_n),
        .load                 (load),
        .cfg_channel_log2     (cfg_channel_log2),
        .cfg_channel_duration (cfg_channel_duration),
        .cfg_guard            (cfg_guard),
        .cfg_mode             (cfg_mode),
        .cfg_frames           (cfg_frames),
        .k                    (k_eff),
        .dur                  (dur_eff),
        .guard                (guard_eff),
        .strobe_en            (strobe_en),
        .mode                 (mode_eff),
        .frames               (frames_eff)
    );

    assign cnt_inc    = cnt + DUR_W'(1);
    assign threshold  = dur_eff - guard_eff;
    assign chan_span  = (IDX_W + 1)'(1) << k_eff;
    assign last_index = chan_span[IDX_W-1:0] - IDX_W'(1);

    // frame_count already holds the post-increment value on the last START_HIGH clock
    assign limit_hit = (frames_eff != 16'd0) && (frame_count == frames_eff);
    assign load      = !abort && enable &&
                       ((state == ST_IDLE) ||
                        (state == ST_START_HIGH && cnt == SH_LAST && !limit_hit));

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            start         <= 1'b1;
            channel       <= 1'b1;
            busy          <= 1'b0;
            channel_index <= '0;
            frame_count   <= 16'd0;
            frame_done    <= 1'b0;
        end else if (abort) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            start         <= 1'b1;
            channel       <= 1'b1;
            busy          <= 1'b0;
            channel_index <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    start   <= 1'b1;
                    channel <= 1'b1;
                    busy    <= 1'b0;
                    if (load) begin
                        state         <= ST_START_LOW;
                        cnt           <= '0;
                        start         <= 1'b0;
                        channel       <= (cfg_mode != START_AND_CHANNEL_SYNC);
                        busy          <= 1'b1;
                        channel_index <= '0;
                        frame_count   <= 16'd0;
                    end
                end

                ST_START_LOW: begin
                    if (cnt == SL_LAST) begin
                        state         <= ST_CHANNEL;
                        cnt           <= '0;
                        channel_index <= '0;
                        start         <= 1'b1;
                        channel       <= 1'b1;
                    end else begin
                        cnt     <= cnt_inc;
                        channel <= (mode_eff != START_AND_CHANNEL_SYNC);
                    end
                end

                // A strobe never covers cnt=0 because an enabled strobe has G < D.
                ST_CHANNEL: begin
                    if (cnt == dur_eff - DUR_W'(1)) begin
                        cnt     <= '0;
                        channel <= 1'b1;
                        if (channel_index == last_index) begin
                            state <= ST_START_HIGH;
                            if (SH_LAST == '0) begin
                                frame_done  <= 1'b1;
                                frame_count <= sat_inc16(frame_count);
                            end
                        end else begin
                            channel_index <= channel_index + IDX_W'(1);
                        end
                    end else begin
                        cnt     <= cnt_inc;
                        channel <= !(strobe_en && (cnt_inc >= threshold));
                    end
                end

                ST_START_HIGH: begin
                    if (cnt == SH_LAST) begin
                        cnt           <= '0;
                        channel_index <= '0;
                        if (load) begin
                            state   <= ST_START_LOW;
                            start   <= 1'b0;
                            channel <= (cfg_mode != START_AND_CHANNEL_SYNC);
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == SH_LAST) begin
                            frame_done  <= 1'b1;
                            frame_count <= sat_inc16(frame_count);
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_messbauer_sequencer.sv
// Self-checking bench for messbauer_sequencer against a cycle-index waveform model
// derived from the frame layout (start-low, 2^k channel periods, start-high).
module tb_messbauer_sequencer;

    localparam int SD   = 4;
    localparam int SHD  = 6;
    localparam int MAXC = 16;
    localparam int DW   = 24;
    localparam int IW   = $clog2(MAXC);

    logic          aclk;
    logic          areset_n;
    logic          enable;
    logic          abort;
    logic [3:0]    cfg_channel_log2;
    logic [DW-1:0] cfg_channel_duration;
    logic [DW-1:0] cfg_guard;
    logic          cfg_mode;
    logic [15:0]   cfg_frames;
    logic          start;
    logic          channel;
    logic          busy;
    logic [IW-1:0] channel_index;
    logic [15:0]   frame_count;
    logic          frame_done;

    int n_compared = 0;
    int n_failed   = 0;

    typedef struct {
        int k;
        int d;
        int g;
        bit mode;
        int frames;
    } cfg_t;

    // Packed view: [23]start [22]channel [21]busy [20]frame_done [19:16]index [15:0]frame_count
    typedef struct {
        logic [23:0] vec;
        logic [23:0] mask;
    } exp_t;

    messbauer_sequencer #(
        .GCLK_PERIOD         (20),
        .START_DURATION      (SD),
        .START_HIGH_DURATION (SHD),
        .MAX_CHANNEL_NUMBER  (MAXC),
        .DUR_W               (DW),
        .IDX_W               (IW)
    ) dut (
        .aclk                 (aclk),
        .areset_n             (areset_n),
        .enable               (enable),
        .abort                (abort),
        .cfg_channel_log2     (cfg_channel_log2),
        .cfg_channel_duration (cfg_channel_duration),
        .cfg_guard            (cfg_guard),
        .cfg_mode             (cfg_mode),
        .cfg_frames           (cfg_frames),
        .start                (start),
        .channel              (channel),
        .busy                 (busy),
        .channel_index        (channel_index),
        .frame_count          (frame_count),
        .frame_done           (frame_done)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int eff_k(cfg_t c);
        if (c.k < 1) return 1;
        if (c.k > IW) return IW;
        return c.k;
    endfunction

    function automatic int eff_d(cfg_t c);
        return (c.d == 0) ? 1 : c.d;
    endfunction

    function automatic int frame_len(cfg_t c);
        return SD + (1 << eff_k(c)) * eff_d(c) + SHD;
    endfunction

    // Expected outputs on clock t (0-based) of frame number frame_no
    function automatic exp_t model(cfg_t c, int frame_no, int t);
        exp_t e;
        int   d;
        int   n;
        int   u;
        bit   strobe;
        d      = eff_d(c);
        n      = 1 << eff_k(c);
        strobe = (c.g != 0) && (c.g < d);
        e.mask = '1;
        e.vec  = {1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 16'(frame_no)};
        if (t < SD) begin
            e.vec[23]       = 1'b0;
            e.vec[22]       = !c.mode;
            e.mask[19:16]   = 4'd0;
        end else if (t < SD + n * d) begin
            u               = t - SD;
            e.vec[19:16]    = 4'(u / d);
            if (strobe && (u % d) >= d - c.g) e.vec[22] = 1'b0;
        end else begin
            e.mask[19:16]   = 4'd0;
            if (t == SD + n * d + SHD - 1) begin
                e.vec[20]   = 1'b1;
                e.vec[15:0] = 16'(frame_no + 1);
            end
        end
        return e;
    endfunction

    function automatic logic [23:0] idle_vec(int fc);
        return {4'b1100, 4'd0, 16'(fc)};
    endfunction

    function automatic logic [23:0] observed();
        return {start, channel, busy, frame_done, channel_index, frame_count};
    endfunction

    task automatic apply_cfg(cfg_t c);
        cfg_channel_log2     = 4'(c.k);
        cfg_channel_duration = DW'(c.d);
        cfg_guard            = DW'(c.g);
        cfg_mode             = c.mode;
        cfg_frames           = 16'(c.frames);
    endtask

    task automatic test_reset();
        cfg_t        c;
        exp_t        e;
        logic [23:0] obs;
        c = '{k:2, d:5, g:2, mode:1'b0, frames:0};
        #1 areset_n = 1'b0;
        #1;
        obs = observed();
        n_compared++;
        if (obs !== idle_vec(0)) begin
            n_failed++;
            $display("[TB] FAIL reset_state: observed %h required %h", obs, idle_vec(0));
        end
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
        obs = observed();
        n_compared++;
        if (obs !== idle_vec(0)) begin
            n_failed++;
            $display("[TB] FAIL idle_after_reset: observed %h required %h", obs, idle_vec(0));
        end
        apply_cfg(c);
        enable = 1'b1;
        for (int t = 0; t <= SD + 7; t++) begin
            @(negedge aclk);
            e   = model(c, 0, t);
            obs = observed();
            n_compared++;
            if ((obs & e.mask) !== (e.vec & e.mask)) begin
                n_failed++;
                $display("[TB] FAIL pre_reset_frame t=%0d: observed %h required %h mask %h", t, obs, e.vec, e.mask);
            end
        end
        #2 areset_n = 1'b0;
        #1;
        obs = observed();
        n_compared++;
        if (obs !== idle_vec(0)) begin
            n_failed++;
            $display("[TB] FAIL async_reset_mid_channel: observed %h required %h", obs, idle_vec(0));
        end
        enable = 1'b0;
        @(negedge aclk);
        areset_n = 1'b1;
    endtask

    task automatic test_single_frame(bit mode);
        cfg_t        c;
        exp_t        e;
        logic [23:0] obs;
        int          pulses;
        c      = '{k:2, d:5, g:2, mode:mode, frames:1};
        pulses = 0;
        @(negedge aclk);
        apply_cfg(c);
        enable = 1'b1;
        for (int t = 0; t < frame_len(c); t++) begin
            @(negedge aclk);
            e   = model(c, 0, t);
            obs = observed();
            if (frame_done === 1'b1) pulses++;
            n_compared++;
            if ((obs & e.mask) !== (e.vec & e.mask)) begin
                n_failed++;
                $display("[TB] FAIL single_frame mode=%0d t=%0d: observed %h required %h mask %h", mode, t, obs, e.vec, e.mask);
            end
        end
        @(negedge aclk);
        obs = observed();
        n_compared++;
        if (obs !== idle_vec(1)) begin
            n_failed++;
            $display("[TB] FAIL single_frame_end mode=%0d: observed %h required %h", mode, obs, idle_vec(1));
        end
        enable = 1'b0;
        n_compared++;
        if (pulses !== 1) begin
            n_failed++;
            $display("[TB] FAIL frame_done_pulses mode=%0d: observed %0d required 1", mode, pulses);
        end
    endtask

    task automatic test_continuous();
        cfg_t        c;
        exp_t        e;
        logic [23:0] obs;
        c = '{k:2, d:3, g:1, mode:1'b0, frames:0};
        @(negedge aclk);
        apply_cfg(c);
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int t = 0; t < frame_len(c); t++) begin
                @(negedge aclk);
                e   = model(c, f, t);
                obs = observed();
                n_compared++;
                if ((obs & e.mask) !== (e.vec & e.mask)) begin
                    n_failed++;
                    $display("[TB] FAIL continuous f=%0d t=%0d: observed %h required %h mask %h", f, t, obs, e.vec, e.mask);
                end
                if (f == 2 && t == SD + eff_d(c)) enable = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            obs = observed();
            n_compared++;
            if (obs !== idle_vec(3)) begin
                n_failed++;
                $display("[TB] FAIL continuous_stop i=%0d: observed %h required %h", i, obs, idle_vec(3));
            end
        end
    endtask

    task automatic test_abort();
        cfg_t        c;
        exp_t        e;
        logic [23:0] obs;
        int          limit;
        c = '{k:2, d:5, g:2, mode:1'b0, frames:0};
        @(negedge aclk);
        apply_cfg(c);
        enable = 1'b1;
        for (int f = 0; f < 2; f++) begin
            limit = (f == 0) ? frame_len(c) - 1 : SD + 2 * eff_d(c);
            for (int t = 0; t <= limit; t++) begin
                @(negedge aclk);
                e   = model(c, f, t);
                obs = observed();
                n_compared++;
                if ((obs & e.mask) !== (e.vec & e.mask)) begin
                    n_failed++;
                    $display("[TB] FAIL abort_run f=%0d t=%0d: observed %h required %h mask %h", f, t, obs, e.vec, e.mask);
                end
            end
        end
        abort = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            obs = observed();
            n_compared++;
            if (obs !== idle_vec(1)) begin
                n_failed++;
                $display("[TB] FAIL abort_idle i=%0d: observed %h required %h", i, obs, idle_vec(1));
            end
        end
        abort  = 1'b0;
        enable = 1'b0;
        @(negedge aclk);
        obs = observed();
        n_compared++;
        if (obs !== idle_vec(1)) begin
            n_failed++;
            $display("[TB] FAIL abort_release: observed %h required %h", obs, idle_vec(1));
        end
    endtask

    task automatic test_boundary();
        cfg_t        cases[4];
        exp_t        e;
        logic [23:0] obs;
        cases[0] = '{k:15, d:1, g:0, mode:1'b0, frames:1};
        cases[1] = '{k:1,  d:5, g:5, mode:1'b1, frames:1};
        cases[2] = '{k:2,  d:0, g:0, mode:1'b0, frames:1};
        cases[3] = '{k:0,  d:2, g:1, mode:1'b0, frames:1};
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            apply_cfg(cases[i]);
            enable = 1'b1;
            for (int t = 0; t < frame_len(cases[i]); t++) begin
                @(negedge aclk);
                e   = model(cases[i], 0, t);
                obs = observed();
                n_compared++;
                if ((obs & e.mask) !== (e.vec & e.mask)) begin
                    n_failed++;
                    $display("[TB] FAIL boundary case=%0d t=%0d: observed %h required %h mask %h", i, t, obs, e.vec, e.mask);
                end
            end
            @(negedge aclk);
            obs = observed();
            n_compared++;
            if (obs !== idle_vec(1)) begin
                n_failed++;
                $display("[TB] FAIL boundary_end case=%0d: observed %h required %h", i, obs, idle_vec(1));
            end
            enable = 1'b0;
        end
    endtask

    task automatic test_cfg_midframe();
        cfg_t        a;
        cfg_t        b;
        exp_t        e;
        logic [23:0] obs;
        a = '{k:1, d:4, g:1, mode:1'b0, frames:2};
        b = '{k:3, d:2, g:1, mode:1'b1, frames:2};
        @(negedge aclk);
        apply_cfg(a);
        enable = 1'b1;
        for (int t = 0; t < frame_len(a); t++) begin
            @(negedge aclk);
            e   = model(a, 0, t);
            obs = observed();
            n_compared++;
            if ((obs & e.mask) !== (e.vec & e.mask)) begin
                n_failed++;
                $display("[TB] FAIL midframe_old t=%0d: observed %h required %h mask %h", t, obs, e.vec, e.mask);
            end
            if (t == SD + 1) apply_cfg(b);
        end
        for (int t = 0; t < frame_len(b); t++) begin
            @(negedge aclk);
            e   = model(b, 1, t);
            obs = observed();
            n_compared++;
            if ((obs & e.mask) !== (e.vec & e.mask)) begin
                n_failed++;
                $display("[TB] FAIL midframe_new t=%0d: observed %h required %h mask %h", t, obs, e.vec, e.mask);
            end
        end
        @(negedge aclk);
        obs = observed();
        n_compared++;
        if (obs !== idle_vec(2)) begin
            n_failed++;
            $display("[TB] FAIL midframe_end: observed %h required %h", obs, idle_vec(2));
        end
        enable = 1'b0;
    endtask

    task automatic test_random();
        cfg_t        c;
        exp_t        e;
        logic [23:0] obs;
        for (int r = 0; r < 5; r++) begin
            c.k      = int'($urandom_range(0, 15));
            c.d      = int'($urandom_range(0, 6));
            c.g      = int'($urandom_range(0, 7));
            c.mode   = 1'($urandom_range(0, 1));
            c.frames = int'($urandom_range(1, 2));
            @(negedge aclk);
            apply_cfg(c);
            enable = 1'b1;
            for (int f = 0; f < c.frames; f++) begin
                for (int t = 0; t < frame_len(c); t++) begin
                    @(negedge aclk);
                    e   = model(c, f, t);
                    obs = observed();
                    n_compared++;
                    if ((obs & e.mask) !== (e.vec & e.mask)) begin
                        n_failed++;
                        $display("[TB] FAIL random r=%0d k=%0d d=%0d g=%0d f=%0d t=%0d: observed %h required %h mask %h",
                                 r, c.k, c.d, c.g, f, t, obs, e.vec, e.mask);
                    end
                end
            end
            @(negedge aclk);
            obs = observed();
            n_compared++;
            if (obs !== idle_vec(c.frames)) begin
                n_failed++;
                $display("[TB] FAIL random_end r=%0d: observed %h required %h", r, obs, idle_vec(c.frames));
            end
            enable = 1'b0;
        end
    endtask

    initial begin
        areset_n             = 1'b1;
        enable               = 1'b0;
        abort                = 1'b0;
        cfg_channel_log2     = 4'd1;
        cfg_channel_duration = DW'(1);
        cfg_guard            = '0;
        cfg_mode             = 1'b0;
        cfg_frames           = 16'd1;

        test_reset();
        test_single_frame(1'b0);
        test_single_frame(1'b1);
        test_continuous();
        test_abort();
        test_boundary();
        test_cfg_midframe();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
